// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and encodings for the unified memory port arbiter.
// Word width, FSM state encodings and grant encodings live here.
package mem_port_arbiter_pkg;

    localparam int DEF_WORD_SIZE = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IF_BUSY = 2'd1,
        ARB_DM_BUSY = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } arb_gnt_e;

endpackage

// File: rtl/mem_port_arbiter_perf_cnt.sv
// arb_perf_cnt: enable-driven free-running counter, wraps modulo 2^W.
// Used by mem_port_arbiter only when ARB_PERF_CNT_EN is defined.
module arb_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-ported variable-latency memory.
// Optional stall/drop counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [WORD_SIZE-1:0] if_addr,
    input  logic                 PCSrcE,
    output logic [WORD_SIZE-1:0] if_rdata,
    output logic                 if_valid,
    output logic                 StallF,
    input  logic                 dm_req,
    input  logic                 dm_we,
    input  logic [WORD_SIZE-1:0] dm_addr,
    input  logic [WORD_SIZE-1:0] dm_wdata,
    output logic [WORD_SIZE-1:0] dm_rdata,
    output logic                 dm_valid,
    output logic                 StallM,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [WORD_SIZE-1:0] cnt_stallF,
    output logic [WORD_SIZE-1:0] cnt_stallM,
    output logic [WORD_SIZE-1:0] cnt_drop
`endif
);

    arb_state_e state_q, state_d;
    arb_gnt_e   last_grant_q, last_grant_d;
    logic       drop_q, drop_d;

    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic [WORD_SIZE-1:0] if_rdata_q, if_rdata_d;
    logic                 if_valid_q, if_valid_d;
    logic [WORD_SIZE-1:0] dm_rdata_q, dm_rdata_d;
    logic                 dm_valid_q, dm_valid_d;

    logic grant_data;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        drop_d       = drop_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        if_valid_d   = 1'b0;
        dm_rdata_d   = dm_rdata_q;
        dm_valid_d   = 1'b0;
        // Ties alternate: data wins unless it had the last grant.
        grant_data   = dm_req & (~if_req | (last_grant_q == GNT_FETCH));

        unique case (state_q)
            ARB_IDLE: begin
                drop_d = 1'b0;
                if (grant_data) begin
                    state_d      = ARB_DM_BUSY;
                    last_grant_d = GNT_DATA;
                    mem_req_d    = 1'b1;
                    mem_we_d     = dm_we;
                    mem_addr_d   = dm_addr;
                    mem_wdata_d  = dm_wdata;
                end else if (if_req) begin
                    state_d      = ARB_IF_BUSY;
                    last_grant_d = GNT_FETCH;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr;
                    mem_wdata_d  = '0;
                end
            end
            ARB_IF_BUSY: begin
                if (mem_ack) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    // A redirect in the ack cycle still kills the result.
                    if (!(drop_q | PCSrcE)) begin
                        if_rdata_d = mem_rdata;
                        if_valid_d = 1'b1;
                    end
                end else if (PCSrcE) begin
                    drop_d = 1'b1;
                end
            end
            ARB_DM_BUSY: begin
                if (mem_ack) begin
                    state_d    = ARB_IDLE;
                    mem_req_d  = 1'b0;
                    dm_valid_d = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GNT_FETCH;
            drop_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            if_valid_q   <= 1'b0;
            dm_rdata_q   <= '0;
            dm_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            drop_q       <= drop_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            if_valid_q   <= if_valid_d;
            dm_rdata_q   <= dm_rdata_d;
            dm_valid_q   <= dm_valid_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_valid  = dm_valid_q;

    assign StallF = if_req & ~if_valid_q;
    assign StallM = dm_req & ~dm_valid_q;

`ifdef ARB_PERF_CNT_EN
    logic drop_evt;

    assign drop_evt = (state_q == ARB_IF_BUSY) & mem_ack & (drop_q | PCSrcE);

    arb_perf_cnt #(.W(WORD_SIZE)) u_cnt_stallf (
        .clk   (clk),
        .rst_n (rst),
        .en    (StallF),
        .cnt   (cnt_stallF)
    );

    arb_perf_cnt #(.W(WORD_SIZE)) u_cnt_stallm (
        .clk   (clk),
        .rst_n (rst),
        .en    (StallM),
        .cnt   (cnt_stallM)
    );

    arb_perf_cnt #(.W(WORD_SIZE)) u_cnt_drop (
        .clk   (clk),
        .rst_n (rst),
        .en    (drop_evt),
        .cnt   (cnt_drop)
    );
`endif

endmodule
